multi_commit_stage: RTL and testbench
=====================================

Name: multi_commit_stage

Overview:
- W-wide in-order commit stage. Each cycle it retires a contiguous ready prefix of up to W ROB head entries.
- Drives up to W register-file write ports.
- Sends stores to data memory through a single registered req/ack port; only one store may be outstanding at a time.
- Detects halt, keeps a retired-instruction counter, and sits between the ROB head and the regfile/memory.

Parameters:
- W, 2, commit width (number of ROB head entries examined per cycle, 1..4)
- XLEN, 32, data and address width
- REG_IDX_W, 5, architectural register index width; index 0 is the zero register
- CNT_W, 64, width of the retired-instruction counter

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- head_valid  in  W  lane i holds a valid ROB entry (lane 0 = oldest)
- head_ready  in  W  lane i has completed execution
- head_dest_reg  in  W*REG_IDX_W  destination register per lane
- head_value  in  W*XLEN  result value, or store data for stores
- head_wr_mem  in  W  lane i is a store
- head_addr  in  W*XLEN  store address
- head_mem_size  in  W*2  store size (byte/half/word)
- head_halt  in  W  lane i is a halt instruction
- retire_cnt  out  $clog2(W+1)  number of ROB entries to pop this cycle
- reg_wr_en  out  W  regfile write enable per lane
- reg_wr_idx  out  W*REG_IDX_W  regfile write index per lane
- reg_wr_data  out  W*XLEN  regfile write data per lane
- mem_req  out  1  store request valid (registered)
- mem_addr  out  XLEN  store address (registered)
- mem_data  out  XLEN  store data (registered)
- mem_size  out  2  store size (registered)
- mem_ack  in  1  memory accepted the store this cycle
- halted  out  1  processor halted (sticky)
- retired_total  out  CNT_W  total instructions retired

Behaviour:
- Reset (async, active-high): st_state=ST_IDLE, mem_req=0, mem_addr/mem_data/mem_size=0, halted=0, retired_total=0. The combinational outputs then evaluate to retire_cnt=0 and reg_wr_en=0.
- Store state machine states: ST_IDLE, ST_BUSY.
- Lane i is eligible when all of the following hold:
  - head_valid[i] & head_ready[i];
  - every lane j<i retires;
  - no lane j<i is a store or a halt;
  - halted=0.
- Retire prefix: retire_cnt = number of consecutive eligible lanes starting from lane 0. The first ineligible lane stops the prefix, even if later lanes are ready.
- Store lane k: eligible only if st_state=ST_IDLE, or (ST_BUSY & mem_ack) in the same cycle. Otherwise the prefix stops before k.
  - On retirement the store is captured at the clock edge: mem_addr/mem_data/mem_size load from lane k, and mem_req=1 from the next cycle.
  - A store terminates the group, so at most one store retires per cycle.
- ST_BUSY handling:
  - mem_req and its payload are held stable until the cycle mem_ack=1.
  - ack without a new capture: ST_IDLE, mem_req=0 next cycle.
  - ack with a same-cycle capture: stay ST_BUSY with the new payload.
  - Non-store lanes keep retiring while ST_BUSY.
- mem_ack while ST_IDLE is ignored.
- Halt lane k: eligible only if no store is pending after this edge, i.e. st_state=ST_IDLE or mem_ack=1 this cycle. It also terminates the group. halted=1 from the next cycle and is sticky until reset; retire_cnt=0 thereafter.
- Register writes are combinational, in the same cycle as retire_cnt:
  - reg_wr_en[i] = lane i retires & !head_wr_mem[i] & !head_halt[i] & dest_reg != 0;
  - reg_wr_idx and reg_wr_data pass through from the lane.
  - Lanes that do not retire have reg_wr_en=0.
- Counter: retired_total += retire_cnt each clock and wraps modulo 2^CNT_W. Halt and store lanes count as retired.
- Reset mid-operation clears the in-flight store. Any ROB-side recovery is the ROB's responsibility.

Test Plan:
- W=2, both lanes ready non-store, dest 3 and 0, values 0xA/0xB -> retire_cnt=2, reg_wr_en=2'b01, retired_total +2 next cycle.
- Lane0 not ready, lane1 ready -> retire_cnt=0, reg_wr_en=0 (no out-of-order retirement).
- Lane0 store addr 0x100 data 0xDEAD, lane1 ALU ready -> retire_cnt=1. Next cycle mem_req=1, addr 0x100. With mem_ack held low 3 cycles, payload stays stable; a following store stalls while ALU ops retire. On ack, mem_req=0 next cycle.
- ST_BUSY with mem_ack=1 and a new store at lane0 (addr 0x200) -> store retires, mem_req stays 1 with addr 0x200 next cycle.
- Halt at lane1 behind a ready ALU op, ST_IDLE -> retire_cnt=2, halted=1 next cycle, then retire_cnt=0 forever. Repeat with ST_BUSY: halt waits for mem_ack.
- Assert reset while ST_BUSY -> mem_req=0, halted=0, retired_total=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multi_commit_stage.sv
// W-wide in-order commit stage: retires a contiguous ready prefix of ROB head
// entries, drives regfile writes, issues one outstanding store and tracks halt.
module multi_commit_stage #(
  parameter int W         = 2,
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5,
  parameter int CNT_W     = 64,
  localparam int RCW      = $clog2(W + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [W-1:0]           head_valid,
  input  logic [W-1:0]           head_ready,
  input  logic [W*REG_IDX_W-1:0] head_dest_reg,
  input  logic [W*XLEN-1:0]      head_value,
  input  logic [W-1:0]           head_wr_mem,
  input  logic [W*XLEN-1:0]      head_addr,
  input  logic [W*2-1:0]         head_mem_size,
  input  logic [W-1:0]           head_halt,
  output logic [RCW-1:0]         retire_cnt,
  output logic [W-1:0]           reg_wr_en,
  output logic [W*REG_IDX_W-1:0] reg_wr_idx,
  output logic [W*XLEN-1:0]      reg_wr_data,
  output logic                   mem_req,
  output logic [XLEN-1:0]        mem_addr,
  output logic [XLEN-1:0]        mem_data,
  output logic [1:0]             mem_size,
  input  logic                   mem_ack,
  output logic                   halted,
  output logic [CNT_W-1:0]       retired_total
);

  typedef enum logic {ST_IDLE, ST_BUSY} st_state_e;

  st_state_e        st_state_q, st_state_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]  mem_data_q, mem_data_d;
  logic [1:0]       mem_size_q, mem_size_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] retired_total_q, retired_total_d;

  // The store slot is free for a new capture when idle or being acked this cycle;
  // a halt uses the same test because it must not leave a store in flight.
  logic             slot_free;
  logic [W-1:0]     lane_ok;
  logic [W-1:0]     retire;
  logic             prefix_go;
  logic             store_fire;
  logic             halt_fire;
  logic [XLEN-1:0]  cap_addr;
  logic [XLEN-1:0]  cap_data;
  logic [1:0]       cap_size;

  assign slot_free = (st_state_q == ST_IDLE) || mem_ack;
  assign lane_ok   = head_valid & head_ready
                   & (~head_wr_mem | {W{slot_free}})
                   & (~head_halt   | {W{slot_free}});

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    retire     = '0;
    retire_cnt = '0;
    prefix_go  = !halted_q && !reset;
    store_fire = 1'b0;
    halt_fire  = 1'b0;
    cap_addr   = '0;
    cap_data   = '0;
    cap_size   = '0;
    for (int i = 0; i < W; i++) begin
      if (prefix_go && lane_ok[i]) begin
        retire[i]  = 1'b1;
        retire_cnt = retire_cnt + RCW'(1);
        if (head_wr_mem[i]) begin
          store_fire = 1'b1;
          cap_addr   = head_addr[i*XLEN +: XLEN];
          cap_data   = head_value[i*XLEN +: XLEN];
          cap_size   = head_mem_size[i*2 +: 2];
        end
        if (head_halt[i]) begin
          halt_fire = 1'b1;
        end
        if (head_wr_mem[i] || head_halt[i]) begin
          prefix_go = 1'b0;
        end
      end else begin
        prefix_go = 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < W; i++) begin
      reg_wr_en[i] = retire[i] && !head_wr_mem[i] && !head_halt[i]
                     && (head_dest_reg[i*REG_IDX_W +: REG_IDX_W] != '0);
    end
  end

  assign reg_wr_idx  = head_dest_reg;
  assign reg_wr_data = head_value;

  always_comb begin
    st_state_d      = st_state_q;
    mem_addr_d      = mem_addr_q;
    mem_data_d      = mem_data_q;
    mem_size_d      = mem_size_q;
    halted_d        = halted_q || halt_fire;
    retired_total_d = retired_total_q + CNT_W'(retire_cnt);
    case (st_state_q)
      ST_IDLE: begin
        if (store_fire) begin
          st_state_d = ST_BUSY;
          mem_addr_d = cap_addr;
          mem_data_d = cap_data;
          mem_size_d = cap_size;
        end
      end
      ST_BUSY: begin
        // store_fire here implies mem_ack, so the new payload replaces the acked one.
        if (store_fire) begin
          mem_addr_d = cap_addr;
          mem_data_d = cap_data;
          mem_size_d = cap_size;
        end else if (mem_ack) begin
          st_state_d = ST_IDLE;
        end
      end
      default: st_state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_state_q      <= ST_IDLE;
      mem_addr_q      <= '0;
      mem_data_q      <= '0;
      mem_size_q      <= '0;
      halted_q        <= 1'b0;
      retired_total_q <= '0;
    end else begin
      st_state_q      <= st_state_d;
      mem_addr_q      <= mem_addr_d;
      mem_data_q      <= mem_data_d;
      mem_size_q      <= mem_size_d;
      halted_q        <= halted_d;
      retired_total_q <= retired_total_d;
    end
  end

  assign mem_req       = (st_state_q == ST_BUSY);
  assign mem_addr      = mem_addr_q;
  assign mem_data      = mem_data_q;
  assign mem_size      = mem_size_q;
  assign halted        = halted_q;
  assign retired_total = retired_total_q;

endmodule

// File: tb/tb_multi_commit_stage.sv
// Self-checking bench for multi_commit_stage: directed scenarios plus random
// traffic compared every cycle against a transaction-level reference model.
module tb_multi_commit_stage;

  localparam int W         = 2;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int CNT_W     = 64;
  localparam int RCW       = $clog2(W + 1);

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic [W-1:0]           head_valid;
  logic [W-1:0]           head_ready;
  logic [W*REG_IDX_W-1:0] head_dest_reg;
  logic [W*XLEN-1:0]      head_value;
  logic [W-1:0]           head_wr_mem;
  logic [W*XLEN-1:0]      head_addr;
  logic [W*2-1:0]         head_mem_size;
  logic [W-1:0]           head_halt;
  logic [RCW-1:0]         retire_cnt;
  logic [W-1:0]           reg_wr_en;
  logic [W*REG_IDX_W-1:0] reg_wr_idx;
  logic [W*XLEN-1:0]      reg_wr_data;
  logic                   mem_req;
  logic [XLEN-1:0]        mem_addr;
  logic [XLEN-1:0]        mem_data;
  logic [1:0]             mem_size;
  logic                   mem_ack;
  logic                   halted;
  logic [CNT_W-1:0]       retired_total;

  multi_commit_stage #(.W(W), .XLEN(XLEN), .REG_IDX_W(REG_IDX_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .head_valid(head_valid), .head_ready(head_ready), .head_dest_reg(head_dest_reg),
    .head_value(head_value), .head_wr_mem(head_wr_mem), .head_addr(head_addr),
    .head_mem_size(head_mem_size), .head_halt(head_halt),
    .retire_cnt(retire_cnt), .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx),
    .reg_wr_data(reg_wr_data), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_size(mem_size), .mem_ack(mem_ack),
    .halted(halted), .retired_total(retired_total)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: one optional in-flight store, sticky halt, counter.
  bit               m_pend;
  logic [XLEN-1:0]  m_addr, m_data;
  logic [1:0]       m_size;
  bit               m_halted;
  logic [CNT_W-1:0] m_total;

  logic [RCW-1:0]   last_cnt;
  logic [W-1:0]     last_en;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic clear_in();
    head_valid = '0; head_ready = '0; head_dest_reg = '0; head_value = '0;
    head_wr_mem = '0; head_addr = '0; head_mem_size = '0; head_halt = '0;
    mem_ack = 1'b0;
  endtask

  task automatic set_lane(input int i, input bit rdy, input int dest, input logic [31:0] val,
                          input bit st, input logic [31:0] addr, input bit hlt);
    head_valid[i] = 1'b1;
    head_ready[i] = rdy;
    head_dest_reg[i*REG_IDX_W +: REG_IDX_W] = REG_IDX_W'(dest);
    head_value[i*XLEN +: XLEN] = val;
    head_wr_mem[i] = st;
    head_addr[i*XLEN +: XLEN] = addr;
    head_mem_size[i*2 +: 2] = 2'd2;
    head_halt[i] = hlt;
  endtask

  task automatic model_reset();
    m_pend = 0; m_addr = '0; m_data = '0; m_size = '0; m_halted = 0; m_total = '0;
  endtask

  // One clock: inputs already driven; check combinational outputs, advance, check state.
  task automatic do_cycle();
    int n;
    int st_lane;
    bit hlt;
    logic [W-1:0] en_exp;
    #1;
    n = 0; st_lane = -1; hlt = 0;
    for (int i = 0; i < W; i++) begin
      if (m_halted) break;
      if (!(head_valid[i] && head_ready[i])) break;
      if ((head_wr_mem[i] || head_halt[i]) && m_pend && !mem_ack) break;
      n++;
      if (head_wr_mem[i]) st_lane = i;
      if (head_halt[i]) hlt = 1;
      if (head_wr_mem[i] || head_halt[i]) break;
    end
    en_exp = '0;
    for (int i = 0; i < n; i++)
      en_exp[i] = !head_wr_mem[i] && !head_halt[i]
                  && (head_dest_reg[i*REG_IDX_W +: REG_IDX_W] != 0);
    last_cnt = retire_cnt;
    last_en  = reg_wr_en;
    check("retire_cnt", 64'(retire_cnt), 64'(n));
    check("reg_wr_en", 64'(reg_wr_en), 64'(en_exp));
    check("reg_wr_data", 64'(reg_wr_data[XLEN +: XLEN]), 64'(head_value[XLEN +: XLEN]));
    @(posedge clock);
    #1;
    if (st_lane >= 0) begin
      m_pend = 1;
      m_addr = head_addr[st_lane*XLEN +: XLEN];
      m_data = head_value[st_lane*XLEN +: XLEN];
      m_size = head_mem_size[st_lane*2 +: 2];
    end else if (m_pend && mem_ack) begin
      m_pend = 0;
    end
    if (hlt) m_halted = 1;
    m_total = m_total + CNT_W'(n);
    check("mem_req", 64'(mem_req), 64'(m_pend));
    if (m_pend) begin
      check("mem_addr", 64'(mem_addr), 64'(m_addr));
      check("mem_data", 64'(mem_data), 64'(m_data));
      check("mem_size", 64'(mem_size), 64'(m_size));
    end
    check("halted", 64'(halted), 64'(m_halted));
    check("retired_total", retired_total, m_total);
  endtask

  // Asynchronous reset mid-cycle: state must clear before any clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_total", retired_total, 64'd0);
    check("rst_retire_cnt", 64'(retire_cnt), 64'd0);
    check("rst_reg_wr_en", 64'(reg_wr_en), 64'd0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    clear_in();
    model_reset();
    reset = 1'b1;
    #12;
    check("init_mem_req", 64'(mem_req), 64'd0);
    check("init_mem_addr", 64'(mem_addr), 64'd0);
    check("init_halted", 64'(halted), 64'd0);
    check("init_total", retired_total, 64'd0);
    check("init_retire_cnt", 64'(retire_cnt), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Two ready ALU ops, dest 3 and 0.
    clear_in();
    set_lane(0, 1, 3, 32'hA, 0, 0, 0);
    set_lane(1, 1, 0, 32'hB, 0, 0, 0);
    do_cycle();
    check("tp_alu_cnt", 64'(last_cnt), 64'd2);
    check("tp_alu_en", 64'(last_en), 64'b01);
    check("tp_alu_total", retired_total, 64'd2);

    // No out-of-order retirement.
    clear_in();
    set_lane(0, 0, 4, 32'h1, 0, 0, 0);
    set_lane(1, 1, 5, 32'h2, 0, 0, 0);
    do_cycle();
    check("tp_ooo_cnt", 64'(last_cnt), 64'd0);

    // Store then ALU: store ends the group.
    clear_in();
    set_lane(0, 1, 0, 32'hDEAD, 1, 32'h100, 0);
    set_lane(1, 1, 6, 32'h3, 0, 0, 0);
    do_cycle();
    check("tp_st_cnt", 64'(last_cnt), 64'd1);
    check("tp_st_req", 64'(mem_req), 64'd1);
    check("tp_st_addr", 64'(mem_addr), 64'h100);
    // Second store stalls for three unacked cycles.
    for (int k = 0; k < 3; k++) begin
      clear_in();
      set_lane(0, 1, 0, 32'hBEEF, 1, 32'h300, 0);
      do_cycle();
      check("tp_stall_cnt", 64'(last_cnt), 64'd0);
      check("tp_stall_addr", 64'(mem_addr), 64'h100);
    end
    // ALU retires while busy, store behind it waits.
    clear_in();
    set_lane(0, 1, 7, 32'h4, 0, 0, 0);
    set_lane(1, 1, 0, 32'hBEEF, 1, 32'h300, 0);
    do_cycle();
    check("tp_busy_alu_cnt", 64'(last_cnt), 64'd1);
    clear_in();
    mem_ack = 1'b1;
    do_cycle();
    check("tp_ack_clear", 64'(mem_req), 64'd0);

    // Ack with a same-cycle new store keeps the port busy.
    clear_in();
    set_lane(0, 1, 0, 32'h11, 1, 32'h100, 0);
    do_cycle();
    clear_in();
    set_lane(0, 1, 0, 32'h22, 1, 32'h200, 0);
    mem_ack = 1'b1;
    do_cycle();
    check("tp_backtoback_cnt", 64'(last_cnt), 64'd1);
    check("tp_backtoback_req", 64'(mem_req), 64'd1);
    check("tp_backtoback_addr", 64'(mem_addr), 64'h200);
    clear_in();
    mem_ack = 1'b1;
    do_cycle();

    // Halt behind an ALU op while idle.
    clear_in();
    set_lane(0, 1, 8, 32'h5, 0, 0, 0);
    set_lane(1, 1, 0, 32'h0, 0, 0, 1);
    do_cycle();
    check("tp_halt_cnt", 64'(last_cnt), 64'd2);
    check("tp_halt_flag", 64'(halted), 64'd1);
    for (int k = 0; k < 3; k++) begin
      clear_in();
      set_lane(0, 1, 9, 32'h6, 0, 0, 0);
      set_lane(1, 1, 10, 32'h7, 0, 0, 0);
      do_cycle();
      check("tp_halted_cnt", 64'(last_cnt), 64'd0);
    end
    do_reset();

    // Halt waits for the outstanding store's ack.
    clear_in();
    set_lane(0, 1, 0, 32'h33, 1, 32'h400, 0);
    do_cycle();
    clear_in();
    set_lane(0, 1, 0, 32'h0, 0, 0, 1);
    do_cycle();
    check("tp_halt_wait_cnt", 64'(last_cnt), 64'd0);
    clear_in();
    set_lane(0, 1, 0, 32'h0, 0, 0, 1);
    mem_ack = 1'b1;
    do_cycle();
    check("tp_halt_ack_cnt", 64'(last_cnt), 64'd1);
    check("tp_halt_ack_flag", 64'(halted), 64'd1);
    do_reset();

    // Reset while a store is outstanding.
    clear_in();
    set_lane(0, 1, 0, 32'h44, 1, 32'h500, 0);
    set_lane(1, 1, 2, 32'h45, 0, 0, 0);
    do_cycle();
    check("tp_pre_rst_req", 64'(mem_req), 64'd1);
    do_reset();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      clear_in();
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(9) < 8) begin
          set_lane(i, ($urandom_range(3) != 0), int'($urandom_range(31)) & (($urandom_range(3) == 0) ? 0 : 31),
                   $urandom, ($urandom_range(3) == 0), $urandom, ($urandom_range(39) == 0));
          head_mem_size[i*2 +: 2] = 2'($urandom_range(2));
        end
      end
      mem_ack = ($urandom_range(9) < 4);
      do_cycle();
      if (m_halted && $urandom_range(3) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
